// File: rtl/bsg_counter_overflow_pkg.sv
// Shared definitions for the multi-channel overflow/set/enable counter:
// overflow mode encoding and the lane-packing helper.
package bsg_counter_overflow_pkg;

  localparam logic e_ovf_wrap = 1'b0;
  localparam logic e_ovf_sat  = 1'b1;

  // LSB position of lane 'lane' in a bus of equal-width lanes packed from bit 0 upward.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/bsg_counter_overflow_set_en_lane.sv
// One counter channel: count register, next-count priority mux,
// threshold comparator and sticky overflow flag.
module bsg_counter_overflow_set_en_lane
  import bsg_counter_overflow_pkg::*;
#(
  parameter int unsigned width_p    = 24,
  parameter int unsigned init_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic [width_p-1:0] max_val_i,
  input  logic               sat_mode_i,
  input  logic               clear_sticky_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o,
  output logic               overflow_sticky_o
);

  logic [width_p-1:0] count_n;

  // Overflow only on exact match; counts above the threshold roll through 2^width_p first.
  always_comb overflow_o = (count_o == max_val_i);

  // Load beats overflow handling; wrap at max happens even without enable.
  always_comb begin
    count_n = count_o;
    if (set_i) begin
      count_n = val_i;
    end else if (overflow_o) begin
      if (sat_mode_i == e_ovf_wrap) begin
        count_n = '0;
      end
    end else if (en_i) begin
      count_n = count_o + width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o           <= width_p'(init_val_p);
      overflow_sticky_o <= 1'b0;
    end else begin
      count_o           <= count_n;
      overflow_sticky_o <= (overflow_sticky_o & ~clear_sticky_i) | overflow_o;
    end
  end

endmodule

// File: rtl/bsg_counter_overflow_set_en_multi.sv
// els_p independent overflow/set/enable counters; this level only slices
// the packed buses and instantiates one lane per channel.
module bsg_counter_overflow_set_en_multi
  import bsg_counter_overflow_pkg::*;
#(
  parameter int unsigned width_p    = 24,
  parameter int unsigned els_p      = 4,
  parameter int unsigned init_val_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           en_i,
  input  logic [els_p-1:0]           set_i,
  input  logic [els_p*width_p-1:0]   val_i,
  input  logic [els_p*width_p-1:0]   max_val_i,
  input  logic [els_p-1:0]           sat_mode_i,
  input  logic [els_p-1:0]           clear_sticky_i,
  output logic [els_p*width_p-1:0]   count_o,
  output logic [els_p-1:0]           overflow_o,
  output logic [els_p-1:0]           overflow_sticky_o
);

  for (genvar i = 0; i < int'(els_p); i++) begin : g_lane
    localparam int unsigned lsb_lp = lane_lsb(i, width_p);

    bsg_counter_overflow_set_en_lane #(
      .width_p    (width_p),
      .init_val_p (init_val_p)
    ) lane (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .en_i              (en_i[i]),
      .set_i             (set_i[i]),
      .val_i             (val_i[lsb_lp +: width_p]),
      .max_val_i         (max_val_i[lsb_lp +: width_p]),
      .sat_mode_i        (sat_mode_i[i]),
      .clear_sticky_i    (clear_sticky_i[i]),
      .count_o           (count_o[lsb_lp +: width_p]),
      .overflow_o        (overflow_o[i]),
      .overflow_sticky_o (overflow_sticky_o[i])
    );
  end

endmodule

// File: tb/tb_bsg_counter_overflow_set_en_multi.sv
// Scoreboard bench: a behavioural model predicts each cycle's counts and flags,
// and a separate monitor compares them against the DUT after every edge.
module tb_bsg_counter_overflow_set_en_multi;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int INIT = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     en, set, sat, clr;
  logic [N*W-1:0]   val, maxv;
  logic [N*W-1:0]   count;
  logic [N-1:0]     ovf, sticky;

  always #5 clk = ~clk;

  bsg_counter_overflow_set_en_multi #(
    .width_p(W), .els_p(N), .init_val_p(INIT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .set_i(set), .val_i(val),
    .max_val_i(maxv), .sat_mode_i(sat), .clear_sticky_i(clr),
    .count_o(count), .overflow_o(ovf), .overflow_sticky_o(sticky)
  );

  typedef struct packed {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   st;
    logic [N-1:0]   ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt[N];
  bit   m_st[N];

  // Model one posedge from the inputs held across it, then queue the post-edge expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      int  mx, nc;
      bit  ov;
      mx = int'(maxv[i*W +: W]);
      ov = (m_cnt[i] == mx);
      if (reset) begin
        nc = INIT;
        m_st[i] = 1'b0;
      end else begin
        m_st[i] = (m_st[i] && !clr[i]) || ov;
        if (set[i])              nc = int'(val[i*W +: W]);
        else if (ov && !sat[i])  nc = 0;
        else if (ov)             nc = m_cnt[i];
        else if (en[i])          nc = (m_cnt[i] + 1) % (1 << W);
        else                     nc = m_cnt[i];
      end
      m_cnt[i] = nc;
      e.cnt[i*W +: W] = W'(nc);
      e.st[i]         = m_st[i];
      e.ov[i]         = (nc == mx);
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare the oldest expectation once outputs have settled after an edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < N; i++) begin
          checks++;
          if (count[i*W +: W] !== e.cnt[i*W +: W]) begin
            errors++;
            $display("FAIL count ch%0d t=%0t: got %0d expected %0d", i, $time, count[i*W +: W], e.cnt[i*W +: W]);
          end
          checks++;
          if (sticky[i] !== e.st[i]) begin
            errors++;
            $display("FAIL sticky ch%0d t=%0t: got %b expected %b", i, $time, sticky[i], e.st[i]);
          end
          checks++;
          if (ovf[i] !== e.ov[i]) begin
            errors++;
            $display("FAIL overflow ch%0d t=%0t: got %b expected %b", i, $time, ovf[i], e.ov[i]);
          end
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic [W-1:0] v, input logic [W-1:0] mx);
    val[ch*W +: W]  = v;
    maxv[ch*W +: W] = mx;
  endtask

  initial begin
    reset = 1'b1; en = '1; set = '1; sat = '0; clr = '0;
    val = {8'd77, 8'd99}; maxv = {8'd200, 8'd200};
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_st[i] = 1'b0; end
    @(negedge clk);
    // Reset dominates set/enable.
    tick(); tick();
    reset = 1'b0; set = '0; en = '0;

    // ch0 wrap at max=3 with continuous enable.
    set_ch(0, 8'd0, 8'd3); set_ch(1, 8'd0, 8'd255);
    set = 2'b01; tick(); set = '0;
    en = 2'b01;
    repeat (8) tick();
    // Clear sticky while idle, then observe wrap without enable.
    clr = 2'b01; en = '0; tick(); clr = '0;
    set = 2'b01; set_ch(0, 8'd3, 8'd3); tick(); set = '0;
    tick(); tick();

    // Saturate mode: hold at max regardless of enable, then reload.
    sat = 2'b01;
    set = 2'b01; tick(); set = '0;
    for (int k = 0; k < 10; k++) begin en[0] = k[0]; tick(); end
    set_ch(0, 8'd1, 8'd3); set = 2'b01; tick(); set = '0;
    // Saturate->wrap while at max wraps on the next edge.
    set_ch(0, 8'd3, 8'd3); set = 2'b01; tick(); set = '0;
    sat = '0; tick(); tick();

    // Clear coinciding with overflow keeps sticky; clear alone then drops it.
    set = 2'b01; set_ch(0, 8'd3, 8'd3); tick(); set = '0;
    clr = 2'b01; tick(); tick(); clr = '0; tick();

    // ch1 loaded above threshold rolls through 255->0 before reaching max.
    set_ch(1, 8'd250, 8'd10); set = 2'b10; tick(); set = '0;
    en = 2'b10;
    repeat (20) tick();

    // Independence: ch1 reloaded each cycle, ch0 counts, then ch0 with max=0.
    en = 2'b01; set = 2'b10; set_ch(1, 8'd7, 8'd10); set_ch(0, 8'd0, 8'd200);
    repeat (6) tick();
    set_ch(0, 8'd0, 8'd0);
    repeat (4) tick();
    sat = 2'b01; repeat (3) tick(); sat = '0;
    set = '0;

    // Modulo counter at max = 2^W-1.
    set_ch(0, 8'd253, 8'd255); set = 2'b01; tick(); set = '0; en = 2'b01;
    repeat (5) tick();

    // Randomised traffic, small thresholds weighted to hit overflow often.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = N'($urandom);
      set   = N'($urandom_range(0, 7) == 0 ? $urandom : 0);
      sat   = N'($urandom);
      clr   = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      for (int i = 0; i < N; i++) begin
        val[i*W +: W]  = W'($urandom);
        maxv[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      end
      tick();
    end
    reset = 1'b0; en = '0; set = '0; clr = '0;

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_counter_overflow_set_en_multi.md
Name: bsg_counter_overflow_set_en_multi

Overview:
- Parametrised, multi-channel successor to the single-channel 24-bit overflow/set/enable counter.
- els_p independent up-counters, each with:
  - a runtime-programmable overflow threshold
  - a per-channel wrap/saturate mode
  - load (set) and enable controls
  - a combinational overflow flag and a sticky overflow flag with clear.
- Used for timeout, credit and epoch counting in network and DMA blocks that previously needed one hard-coded counter per channel.

Parameters:
- width_p, 24, counter width in bits per channel (>=1).
- els_p, 4, number of independent channels (>=1).
- init_val_p, 0, count value loaded on reset (must be < 2^width_p).

Ports:
- clk_i  in  1  sole clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  els_p  per-channel count enable.
- set_i  in  els_p  per-channel load strobe.
- val_i  in  els_p*width_p  load values; channel i at bits [i*width_p +: width_p].
- max_val_i  in  els_p*width_p  overflow thresholds, same packing; sampled every cycle (not latched).
- sat_mode_i  in  els_p  per channel: 1 = saturate, 0 = wrap.
- clear_sticky_i  in  els_p  per-channel clear of the sticky flag.
- count_o  out  els_p*width_p  current counts, same packing; registered.
- overflow_o  out  els_p  combinational: count_o[i] == max_val_i[i].
- overflow_sticky_o  out  els_p  registered sticky overflow flag.

Behaviour:
- Reset: the rule is decided as one clock, synchronous active-high reset_i.
  - While reset_i=1 at posedge: every count_o[i] <= init_val_p and overflow_sticky_o <= 0.
  - Reset overrides set_i, en_i and clear_sticky_i.
  - overflow_o after reset reflects init_val_p == max_val_i.
- Next-count priority per channel, evaluated at each posedge (first match wins):
  1. reset_i -> init_val_p.
  2. set_i[i] -> val_i[i] (loads even if the counter is at overflow; en_i ignored).
  3. overflow_o[i] and sat_mode_i[i]=0 -> 0.
     - This wrap happens unconditionally, even with en_i[i]=0, matching the existing family: on reaching max the counter clears on the next edge.
  4. overflow_o[i] and sat_mode_i[i]=1 -> hold at max, regardless of en_i.
  5. en_i[i] -> count+1, modulo 2^width_p.
  6. otherwise hold.
- Latency: one cycle from en/set to count_o. overflow_o has zero-cycle latency from count_o or max_val_i.
- Count above threshold (loaded via set, or max_val_i lowered at runtime):
  - no overflow is detected;
  - the counter increments with en and rolls from 2^width_p-1 to 0 naturally, then counts up to max.
- max_val_i=0:
  - wrap mode: count sits at 0 with overflow_o=1 every cycle;
  - saturate mode: count holds 0.
- max_val_i = 2^width_p-1: wrap mode behaves as a plain modulo-2^width_p counter.
- Sticky flag:
  - overflow_sticky_o[i] <= (overflow_sticky_o[i] & ~clear_sticky_i[i]) | overflow_o[i].
  - Overflow in the same cycle as clear: set wins.
  - Visible one cycle after overflow_o.
- sat_mode_i change while at max:
  - 1->0: the wrap applies on the very next edge.
  - 0->1: holds.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Package bsg_counter_overflow_pkg:
  - mode encoding constants (e_ovf_wrap=0, e_ovf_sat=1);
  - a function packing/unpacking lane slices.
- Sub-module bsg_counter_overflow_set_en_lane:
  - one channel: counter register, next-state mux, comparator, sticky flop;
  - parametrised by width_p and init_val_p;
  - instantiated els_p times in a generate loop.
- The top module holds only the slicing and instantiation.

Test Plan:
- Reset with init_val_p=5, width_p=8, els_p=2 -> count_o = {5,5}, overflow_sticky_o=0; set_i asserted during reset is ignored.
- ch0: max=3, wrap, en=1 continuously from 0 -> counts 0,1,2,3,0,1. overflow_o high only at 3; sticky high one cycle later and stays high until clear_sticky_i.
- ch0: max=3, wrap, en=0 after reaching 3 -> next cycle count=0 anyway. Same test with sat=1 -> holds 3 for 10 cycles; set_i with val=1 -> count=1 next cycle.
- ch1: set val=250, max=10, width_p=8, en=1 -> 251..255,0,1..10, then wrap to 0. overflow_o never asserts above max.
- clear_sticky_i and overflow in the same cycle -> sticky remains 1. Clear alone next cycle -> sticky 0.
- Independence: ch0 enabled, ch1 set every cycle to 7 -> ch1 stays 7 while ch0 counts normally. max_val_i=0 on ch0 in wrap mode -> count 0, overflow_o constantly 1.
